// File: rtl/simon_seq_player_if.sv
// Blink command handshake between the sequence player and the LED blinker.
interface simon_seq_player_if;
    logic       blink_valid;
    logic       blink_ready;
    logic [1:0] blink_idx;

    modport master (output blink_valid, output blink_idx, input blink_ready);
    modport slave  (input blink_valid, input blink_idx, output blink_ready);
endinterface

// File: rtl/simon_seq_player.sv
// Simon Says sequence store: grows the sequence from a free-running LFSR and
// replays it as blink commands over a valid/ready handshake.
module simon_seq_player #(
    parameter int          MAX_LEN    = 16,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          GAP_CYCLES = 8
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                extend,
    input  logic                start,
    simon_seq_player_if.master  blink,
    output logic                busy,
    output logic                done,
    output logic [4:0]          length,
    output logic                full,
    input  logic [3:0]          rd_addr,
    output logic [1:0]          rd_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int              GAP_W     = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [4:0]      LEN_MAX   = 5'(MAX_LEN);
    localparam logic [15:0]     LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

    state_t           state_r, state_s;
    logic [3:0]       ptr_r, ptr_s;
    logic [GAP_W-1:0] gap_r, gap_s;
    logic [4:0]       length_r, len_eff_s;
    logic             full_r;
    logic [15:0]      lfsr_r;
    logic [1:0]       mem_r [16];
    logic             valid_r, busy_r, done_r;
    logic [1:0]       idx_r, idx_s;
    logic             ext_ok_s, last_s;

    // Next-state, pointer, gap counter and next blink index.
    always_comb begin
        state_s   = state_r;
        ptr_s     = ptr_r;
        gap_s     = gap_r;
        ext_ok_s  = (state_r == IDLE) && extend && (length_r < LEN_MAX);
        len_eff_s = ext_ok_s ? (length_r + 5'd1) : length_r;
        last_s    = ({1'b0, ptr_r} == (length_r - 5'd1));

        case (state_r)
            IDLE: begin
                if (start) begin
                    if (len_eff_s != 5'd0) begin
                        state_s = PLAY;
                        ptr_s   = 4'd0;
                    end else begin
                        state_s = DONE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            PLAY: begin
                if (blink.blink_ready) begin
                    if (last_s) begin
                        state_s = DONE;
                    end else begin
                        ptr_s = ptr_r + 4'd1;
                        if (GAP_CYCLES > 0) begin
                            state_s = GAP;
                            gap_s   = {GAP_W{1'b0}};
                        end else begin
                            state_s = PLAY;
                        end
                    end
                end else begin
                    state_s = PLAY;
                end
            end
            GAP: begin
                if (gap_r == GAP_LAST) begin
                    state_s = PLAY;
                    gap_s   = {GAP_W{1'b0}};
                end else begin
                    gap_s = gap_r + {{(GAP_W-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // A same-cycle append at the first playback slot is forwarded from the LFSR.
        if (ext_ok_s && (length_r[3:0] == ptr_s)) begin
            idx_s = lfsr_r[1:0];
        end else begin
            idx_s = mem_r[ptr_s];
        end
    end

    // State, counters, LFSR and registered outputs.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r  <= IDLE;
            ptr_r    <= 4'd0;
            gap_r    <= {GAP_W{1'b0}};
            length_r <= 5'd0;
            full_r   <= 1'b0;
            lfsr_r   <= SEED;
            valid_r  <= 1'b0;
            idx_r    <= 2'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            ptr_r    <= ptr_s;
            gap_r    <= gap_s;
            length_r <= len_eff_s;
            full_r   <= (len_eff_s == LEN_MAX);
            lfsr_r   <= lfsr_step(lfsr_r);
            valid_r  <= (state_s == PLAY);
            idx_r    <= idx_s;
            busy_r   <= (state_s != IDLE);
            done_r   <= (state_s == DONE);
        end
    end

    // Sequence storage; contents survive reset.
    always_ff @(posedge CLOCK_50) begin
        if (ext_ok_s && !reset) begin
            mem_r[length_r[3:0]] <= lfsr_r[1:0];
        end
    end

    assign blink.blink_valid = valid_r;
    assign blink.blink_idx   = idx_r;
    assign busy              = busy_r;
    assign done              = done_r;
    assign length            = length_r;
    assign full              = full_r;
    assign rd_data           = mem_r[rd_addr];

endmodule

// File: doc/simon_seq_player.md
Name: simon_seq_player

Overview:
- Upstream stage of the LED blinker in the Simon Says game.
- Builds the game sequence one random element per round from a free-running LFSR and stores it in on-chip registers.
- On request, replays the whole sequence as blink commands to the blinker over a valid/ready handshake.
- Exposes a combinational read port so the player-input checker can compare key presses against the stored sequence.

Parameters:
- MAX_LEN, 16, sequence capacity in elements; 2 to 16.
- SEED, 16'hACE1, LFSR reset value; must be nonzero.
- GAP_CYCLES, 8, idle cycles inserted between consecutive blink commands; 0 means no gap.

Ports:
- CLOCK_50  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- extend  input  1  one-cycle pulse: append one random element.
- start  input  1  one-cycle pulse: play back the stored sequence.
- blink_ready  input  1  blinker can accept a command.
- blink_valid  output  1  a command is presented on blink_idx.
- blink_idx  output  2  LED index, 0 to 3, to blink.
- busy  output  1  playback in progress; high in every state except IDLE.
- done  output  1  one-cycle pulse when playback completes.
- length  output  5  number of stored elements, 0 to MAX_LEN.
- full  output  1  length == MAX_LEN.
- rd_addr  input  4  checker read address.
- rd_data  output  2  mem[rd_addr], combinational; don't-care when rd_addr >= length.

Behaviour:
- Reset, synchronous, active-high; applies even mid-playback. Takes effect at the next edge:
  - blink_valid=0, blink_idx=0, busy=0, done=0, length=0, full=0;
  - state=IDLE, playback pointer=0, gap counter=0, LFSR=SEED.
  - Memory contents need not be cleared.
- LFSR:
  - 16-bit Galois, right-shift, tap mask 16'hB400.
  - Each cycle: lsb = lfsr[0]; lfsr >>= 1; if lsb, lfsr ^= 16'hB400.
  - Advances every non-reset cycle regardless of state; player timing supplies the entropy.
- Extend:
  - Accepted only in IDLE with length < MAX_LEN.
  - Writes the current-cycle lfsr[1:0] to mem[length]; length increments at the same edge.
  - Ignored when full or not in IDLE; no error is flagged.
- States: IDLE, PLAY, GAP, DONE.
  - IDLE, start=1, effective length > 0 -> PLAY; ptr=0. Effective length is length after any same-cycle extend.
  - IDLE, start=1, effective length = 0 -> DONE.
  - PLAY: blink_valid=1, blink_idx=mem[ptr]. blink_idx stays stable while valid and !ready.
  - PLAY, transfer (valid & ready), not last (ptr < length-1) -> ptr++; go to GAP if GAP_CYCLES>0, else stay in PLAY with blink_valid continuously high.
  - PLAY, transfer on last element -> DONE; no gap after the last element.
  - GAP: blink_valid=0. Counts GAP_CYCLES cycles, then -> PLAY.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Simultaneous extend and start in IDLE:
  - Both take effect; the append happens first.
  - Playback covers the new length, including the new element.
- start, extend or reset-free pulses outside IDLE are ignored.
- blink_ready while blink_valid=0 has no effect.
- Latency:
  - start sampled at edge k -> blink_valid=1 from cycle k+1.
  - Final transfer at edge m -> done=1 during cycle m+1.
- Throughput with GAP_CYCLES=0 and blink_ready held high: one element per cycle.
- Widths: length is 5 bits so 16 is representable. ptr is 4 bits and never exceeds length-1.

Test Plan:
- Deterministic LFSR:
  - Stimulus: deassert reset, then hold extend high for the first three cycles.
  - Expected: mem = {1,0,0} (LFSR values 0xACE1, 0xE270, 0x7138); length=3; rd_addr=0 gives rd_data=1.
- Playback with gaps:
  - Stimulus: length=3, GAP_CYCLES=8, blink_ready tied to 1, pulse start.
  - Expected: exactly 3 single-cycle transfers carrying idx 1,0,0; each pair 9 cycles apart; done pulses one cycle after the third transfer; busy high from the cycle after start until done.
- Backpressure:
  - Stimulus: blink_ready held low for 20 cycles during PLAY.
  - Expected: blink_valid stays high and blink_idx stays constant; the transfer occurs on the first ready cycle; no element is skipped or duplicated.
- Capacity:
  - Stimulus: 20 extend pulses with MAX_LEN=16.
  - Expected: length saturates at 16; full=1; mem[0..15] unchanged by pulses 17 to 20.
- Edge cases:
  - start with length=0 -> done one cycle later, blink_valid never asserts.
  - Simultaneous start and extend at length=2 -> 3 blinks.
  - extend during PLAY -> ignored.
- Reset mid-playback:
  - Stimulus: reset asserted after the second transfer.
  - Expected: next cycle blink_valid=0, busy=0, length=0, no done pulse; re-extend reproduces the value sequence 1,0,0.
